// File: rtl/mmio_defs.sv
// Shared register map and status layout for the MMIO output port.
package mmio_defs;

   // I/O window base; the window is address[31:12]==0 with address[11]==1.
   localparam logic [31:0] MMIO_BASE = 32'h800;

   // Register offsets inside the window (byte offsets, word aligned).
   localparam logic [10:0] OFF_DATA   = 11'h000;
   localparam logic [10:0] OFF_STATUS = 11'h004;
   localparam logic [10:0] OFF_CTRL   = 11'h008;
   localparam logic [10:0] OFF_HALT   = 11'h7FC;

   // STATUS word layout: {23'b0, overflow, full, empty, count[5:0]}.
   localparam int unsigned CNT_W      = 6;
   localparam int unsigned STAT_EMPTY = 6;
   localparam int unsigned STAT_FULL  = 7;
   localparam int unsigned STAT_OVF   = 8;

   typedef enum logic [2:0] {
      RegNone,
      RegData,
      RegStatus,
      RegCtrl,
      RegHalt
   } reg_sel_e;

   // True when the address falls in the I/O window.
   function automatic logic in_window(input logic [31:0] addr);
      return (addr[31:12] == 20'h0) && addr[11];
   endfunction

   // Map an address to the register it selects; address[1:0] is ignored.
   function automatic reg_sel_e reg_decode(input logic [31:0] addr);
      logic [10:0] off;
      off = {addr[10:2], 2'b00};
      if (!in_window(addr)) return RegNone;
      case (off)
         OFF_DATA:   return RegData;
         OFF_STATUS: return RegStatus;
         OFF_CTRL:   return RegCtrl;
         OFF_HALT:   return RegHalt;
         default:    return RegNone;
      endcase
   endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Store FIFO: DEPTH words, wrap-around pointers one bit wider than the index.
module mmio_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_q, rd_q;
   logic             do_push, do_pop;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign count = wr_q - rd_q;
   assign rdata = mem[rd_q[AW-1:0]];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointer update; flush wins and discards any concurrent pop.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_q <= '0;
         rd_q <= '0;
      end else if (flush) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PtrOne;
         if (do_pop)  rd_q <= rd_q + PtrOne;
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/mmio_out_port.sv
// I/O window responder: decodes core stores/loads, feeds the store FIFO, holds overflow/halt.
module mmio_out_port
   import mmio_defs::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   input  logic        we,
   output logic [31:0] data_out,
   output logic        sel,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready,
   output logic        halt
);

   reg_sel_e    rsel;
   logic        wr, push, pop, flush, halt_set;
   logic        full, empty;
   logic [AW:0] count;
   logic        overflow_q, halt_q;
   logic [31:0] status;

   assign rsel     = reg_decode(address);
   assign sel      = in_window(address);
   assign wr       = we && sel;
   assign push     = wr && (rsel == RegData);
   assign flush    = wr && (rsel == RegCtrl) && data_in[0];
   assign halt_set = wr && (rsel == RegHalt);

   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign halt      = halt_q;

   mmio_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .WIDTH (32)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .pop    (pop),
      .flush  (flush),
      .wdata  (data_in),
      .rdata  (out_data),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );

   // Sticky overflow: a push that the full FIFO cannot take; cleared only by flush.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overflow_q <= 1'b0;
      end else if (flush) begin
         overflow_q <= 1'b0;
      end else if (push && full && !pop) begin
         overflow_q <= 1'b1;
      end
   end

   // Halt flag stays set until reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         halt_q <= 1'b0;
      end else if (halt_set) begin
         halt_q <= 1'b1;
      end
   end

   // Assemble the STATUS word.
   always_comb begin
      status                 = '0;
      status[CNT_W-1:0]      = CNT_W'(count);
      status[STAT_EMPTY]     = empty;
      status[STAT_FULL]      = full;
      status[STAT_OVF]       = overflow_q;
   end

   // Combinational read mux; everything outside the readable registers returns 0.
   always_comb begin
      data_out = '0;
      case (rsel)
         RegStatus: data_out = status;
         RegHalt:   data_out = {31'b0, halt_q};
         default:   data_out = '0;
      endcase
   end

endmodule

// File: tb/tb_mmio_out_port.sv
// Randomized self-checking bench for mmio_out_port against a queue-based reference model.
module tb_mmio_out_port;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] address, data_in, data_out, out_data;
   logic        we, sel, out_valid, out_ready, halt;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [31:0] mq[$];
   logic        m_ovf, m_halt;

   mmio_out_port #(
      .DEPTH (8),
      .AW    (3)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .address   (address),
      .data_in   (data_in),
      .we        (we),
      .data_out  (data_out),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .halt      (halt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic exp_sel(input logic [31:0] a);
      return (a[31:12] == 20'h0) && a[11];
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      logic [31:0] wa;
      int          n;
      wa = {a[31:2], 2'b00};
      n  = mq.size();
      if (!exp_sel(a)) return 32'h0;
      if (wa == 32'h804) return {23'b0, m_ovf, n == 8, n == 0, 6'(n)};
      if (wa == 32'hFFC) return {31'b0, m_halt};
      return 32'h0;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf  = 1'b0;
      m_halt = 1'b0;
   endtask

   // One clock edge of the register map and FIFO rules.
   task automatic model_update(input logic [31:0] a, input logic [31:0] d, input logic w,
                               input logic r);
      logic [31:0] wa;
      logic        hit, pop, push;
      wa   = {a[31:2], 2'b00};
      hit  = exp_sel(a) && w;
      pop  = (mq.size() != 0) && r;
      push = hit && (wa == 32'h800);
      if (hit && wa == 32'h808 && d[0]) begin
         mq.delete();
         m_ovf = 1'b0;
         return;
      end
      if (hit && wa == 32'hFFC) m_halt = 1'b1;
      if (push && mq.size() == 8 && !pop) m_ovf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push && mq.size() < 8) mq.push_back(d);
   endtask

   // Drive one cycle: check combinational outputs, then clock and advance the model.
   task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic r, input string tag);
      address   = a;
      data_in   = d;
      we        = w;
      out_ready = r;
      #2;
      check({tag, "_sel"}, {31'b0, sel}, {31'b0, exp_sel(a)});
      check({tag, "_rd"}, data_out, exp_read(a));
      check({tag, "_valid"}, {31'b0, out_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) check({tag, "_head"}, out_data, mq[0]);
      check({tag, "_halt"}, {31'b0, halt}, {31'b0, m_halt});
      @(posedge clk);
      if (resetn) model_update(a, d, w, r);
      #1;
   endtask

   // Combinational read without a clock edge.
   task automatic peek(input logic [31:0] a, output logic [31:0] v);
      address   = a;
      we        = 1'b0;
      out_ready = 1'b0;
      #1;
      v = data_out;
   endtask

   function automatic logic [31:0] pick_addr(input int k);
      case (k)
         0, 1, 2, 3, 4, 5: return 32'h800;
         6, 7, 14:         return 32'h804;
         8:                return 32'h808;
         9:                return 32'hFFC;
         10:               return 32'h900;
         11:               return 32'h000;
         12:               return 32'h80C;
         13:               return 32'h1800;
         default:          return 32'h802;
      endcase
   endfunction

   initial begin
      logic [31:0] v;
      logic [31:0] a;
      logic [31:0] d;

      // 1: reset held with a pending store; nothing may be captured.
      resetn = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) step(32'h800, 32'hDEAD_0000 + i, 1'b1, 1'b0, "rst_hold");
      peek(32'h804, v);
      check("rst_status", v, 32'h040);
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      check("rst_halt", {31'b0, halt}, 32'h0);
      resetn = 1'b1;

      // 2: three pushes, then drain in order.
      step(32'h800, 32'h11, 1'b1, 1'b0, "t2_push");
      step(32'h800, 32'h22, 1'b1, 1'b0, "t2_push");
      step(32'h800, 32'h33, 1'b1, 1'b0, "t2_push");
      peek(32'h804, v);
      check("t2_status", v, 32'h003);
      check("t2_head", out_data, 32'h11);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t2_drain", out_data, 32'h11 * (i + 1));
         step(32'h000, 32'h0, 1'b0, 1'b1, "t2_pop");
      end
      check("t2_empty", {31'b0, out_valid}, 32'h0);

      // 3: overflow on the ninth push, then flush.
      for (int i = 0; i < 9; i++) step(32'h800, 32'h100 + i, 1'b1, 1'b0, "t3_push");
      peek(32'h804, v);
      check("t3_status", v, 32'h188);
      check("t3_head", out_data, 32'h100);
      step(32'h808, 32'h1, 1'b1, 1'b0, "t3_flush");
      peek(32'h804, v);
      check("t3_flushed", v, 32'h040);

      // 4: push and pop together on a full FIFO.
      for (int i = 0; i < 8; i++) step(32'h800, 32'h200 + i, 1'b1, 1'b0, "t4_fill");
      step(32'h800, 32'hAA, 1'b1, 1'b1, "t4_both");
      peek(32'h804, v);
      check("t4_status", v, 32'h088);
      check("t4_head", out_data, 32'h201);
      step(32'h808, 32'h1, 1'b1, 1'b0, "t4_flush");

      // 5: halt, and accesses that must not touch state.
      step(32'h800, 32'h55, 1'b1, 1'b0, "t5_push");
      step(32'hFFC, 32'h0, 1'b1, 1'b0, "t5_halt");
      check("t5_halt", {31'b0, halt}, 32'h1);
      peek(32'hFFC, v);
      check("t5_rd_halt", v, 32'h1);
      step(32'h900, 32'h1, 1'b1, 1'b0, "t5_w900");
      step(32'h000, 32'h0, 1'b0, 1'b0, "t5_r000");
      peek(32'h000, v);
      check("t5_sel0", {31'b0, sel}, 32'h0);
      check("t5_rd0", v, 32'h0);
      peek(32'h804, v);
      check("t5_status", v, 32'h001);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         a = pick_addr($urandom_range(0, 15));
         d = $urandom;
         if (a == 32'h808) d[0] = ($urandom % 4 == 0);
         step(a, d, ($urandom % 4) != 0, ($urandom % 3) == 0, "rnd");
      end

      // 6: asynchronous reset mid-drain.
      step(32'h808, 32'h1, 1'b1, 1'b0, "t6_flush");
      for (int i = 0; i < 5; i++) step(32'h800, 32'h300 + i, 1'b1, 1'b0, "t6_fill");
      step(32'h000, 32'h0, 1'b0, 1'b1, "t6_drain");
      check("t6_pre_valid", {31'b0, out_valid}, 32'h1);
      #2;
      resetn = 1'b0;
      model_reset();
      #1;
      check("t6_async_valid", {31'b0, out_valid}, 32'h0);
      @(posedge clk);
      #1;
      step(32'h804, 32'h0, 1'b0, 1'b1, "t6_in_rst");
      resetn = 1'b1;
      step(32'h804, 32'h0, 1'b0, 1'b0, "t6_after");
      peek(32'h804, v);
      check("t6_status", v, 32'h040);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
